// File: rtl/count_event_queue.sv
// Watches the upstream counter, turns every value change into a tagged event
// (new value, wrap flag, timestamp) and queues it for a valid/ready consumer.
module count_event_queue #(
  parameter int COUNT_WIDTH = 5,
  parameter int DEPTH       = 4,
  parameter int STAMP_WIDTH = 8,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                     count_event_queue_clock,
  input  logic                     count_event_queue_reset,
  input  logic [COUNT_WIDTH-1:0]   count_event_queue_count_in,
  input  logic                     count_event_queue_enable,
  input  logic                     count_event_queue_clear_drops,
  output logic                     count_event_queue_event_valid,
  input  logic                     count_event_queue_event_ready,
  output logic [COUNT_WIDTH-1:0]   count_event_queue_event_value,
  output logic                     count_event_queue_event_wrap,
  output logic [STAMP_WIDTH-1:0]   count_event_queue_event_stamp,
  output logic [$clog2(DEPTH):0]   count_event_queue_occupancy,
  output logic [DROP_WIDTH-1:0]    count_event_queue_drop_count,
  output logic                     count_event_queue_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  logic [COUNT_WIDTH-1:0] value_mem [DEPTH];
  logic                   wrap_mem  [DEPTH];
  logic [STAMP_WIDTH-1:0] stamp_mem [DEPTH];

  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [OCC_W-1:0]       occupancy;
  logic [STAMP_WIDTH-1:0] stamp;
  logic [COUNT_WIDTH-1:0] prev_count;
  logic                   prev_valid;
  logic [DROP_WIDTH-1:0]  drop_count;
  logic                   overflow;

  logic push;
  logic pop;
  logic full;
  logic do_push;
  logic drop;

  // Handshake: the head entry transfers at a rising edge where valid && ready
  // are both high; while valid && !ready the head outputs are held unchanged.
  // valid depends only on stored state, never combinationally on ready.
  always_comb begin
    push    = prev_valid && count_event_queue_enable &&
              (count_event_queue_count_in != prev_count);
    pop     = (occupancy != '0) && count_event_queue_event_ready;
    full    = (occupancy == OCC_FULL);
    do_push = push && (!full || pop);
    drop    = push && full && !pop;
  end

  always_ff @(posedge count_event_queue_clock or negedge count_event_queue_reset) begin
    if (!count_event_queue_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        value_mem[i] <= '0;
        wrap_mem[i]  <= 1'b0;
        stamp_mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occupancy  <= '0;
      stamp      <= '0;
      prev_count <= '0;
      prev_valid <= 1'b0;
    end else begin
      stamp      <= stamp + 1'b1;
      prev_count <= count_event_queue_count_in;
      prev_valid <= 1'b1;
      if (do_push) begin
        value_mem[wr_ptr] <= count_event_queue_count_in;
        wrap_mem[wr_ptr]  <= (count_event_queue_count_in < prev_count);
        stamp_mem[wr_ptr] <= stamp;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !pop) begin
        occupancy <= occupancy + OCC_ONE;
      end else if (pop && !do_push) begin
        occupancy <= occupancy - OCC_ONE;
      end
    end
  end

  // A clear in the same cycle as a drop leaves exactly that one drop recorded.
  always_ff @(posedge count_event_queue_clock or negedge count_event_queue_reset) begin
    if (!count_event_queue_reset) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (count_event_queue_clear_drops) begin
      drop_count <= drop ? DROP_WIDTH'(1) : '0;
      overflow   <= drop;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end
    end
  end

  assign count_event_queue_event_valid = (occupancy != '0);
  assign count_event_queue_event_value = value_mem[rd_ptr];
  assign count_event_queue_event_wrap  = wrap_mem[rd_ptr];
  assign count_event_queue_event_stamp = stamp_mem[rd_ptr];
  assign count_event_queue_occupancy   = occupancy;
  assign count_event_queue_drop_count  = drop_count;
  assign count_event_queue_overflow    = overflow;

endmodule
